// File: rtl/histogram_frame_controller_pkg.sv
// Shared constants and state encoding for the histogram frame controller.
// IMWIDTH / IMHEIGHT are the image geometry and are also the x- and
// y-histogram lengths used by the histogram block.
package histogram_frame_controller_pkg;

  localparam int IMWIDTH       = 240;
  localparam int IMHEIGHT      = 180;
  localparam int READ_LEN      = IMWIDTH + 1;
  localparam int CLEAR_TIMEOUT = 512;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 10;

  localparam logic [ADDR_W-1:0] X_LAST     = ADDR_W'(IMWIDTH - 1);
  localparam logic [ADDR_W-1:0] Y_LAST     = ADDR_W'(IMHEIGHT - 1);
  localparam logic [CNT_W-1:0]  CLEAR_LAST = CNT_W'(CLEAR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  READ_LAST  = CNT_W'(READ_LEN - 1);

  // 3-bit state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_ACCUM  = 3'd3;
  localparam logic [2:0] ST_FLUSH  = 3'd4;
  localparam logic [2:0] ST_READ   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    CLEAR  = ST_CLEAR,
    SETTLE = ST_SETTLE,
    ACCUM  = ST_ACCUM,
    FLUSH  = ST_FLUSH,
    READ   = ST_READ,
    DONE   = ST_DONE
  } ctrlState_t;

endpackage

// File: rtl/histogram_frame_controller_raster_addr_gen.sv
// Raster x/y address generator for one 240x180 frame.
// Ports:
//   clk, reset     - clock, synchronous active-low reset
//   clear          - force x=y=0 (start of a frame)
//   advance        - step one pixel in raster order
//   x, y           - current column / row
//   lastPixel      - high while (x,y) is the final pixel of the frame
module histogram_frame_controller_raster_addr_gen
  import histogram_frame_controller_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] x,
  output logic [ADDR_W-1:0] y,
  output logic              lastPixel
);

  assign lastPixel = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        // Wrap y as well on the final pixel so the counters idle at origin.
        y <= (y == Y_LAST) ? '0 : y + 8'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

endmodule

// File: rtl/histogram_frame_controller.sv
// Frame sequencer for the histogram accumulator:
// clear tables -> accumulate streamed pixels -> read out tables -> done.
// Ports:
//   clk, reset                  - clock, synchronous active-low reset
//   frameStart                  - start a frame (only honoured in IDLE)
//   pixValid, pixData, pixReady - upstream binary pixel handshake
//   xAddress, yAddress,
//   pixelData, startHistogram   - accumulate write to the histogram
//   clearHistogram,
//   histogramCleared            - clear sweep request / completion
//   readHistogram               - read sweep request (READ_LEN cycles)
//   busy, frameDone, clearError - status (clearError is sticky)
// All outputs are registered; they are loaded from the next-state values so
// each strobe lines up exactly with the state it belongs to.
module histogram_frame_controller
  import histogram_frame_controller_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              frameStart,
  input  logic              pixValid,
  input  logic              pixData,
  output logic              pixReady,
  output logic [ADDR_W-1:0] xAddress,
  output logic [ADDR_W-1:0] yAddress,
  output logic              pixelData,
  output logic              startHistogram,
  output logic              clearHistogram,
  input  logic              histogramCleared,
  output logic              readHistogram,
  output logic              busy,
  output logic              frameDone,
  output logic              clearError
);

  ctrlState_t        state, stateNext;
  logic [CNT_W-1:0]  cycleCount, cycleCountNext;
  logic [ADDR_W-1:0] xAddressNext, yAddressNext;
  logic [ADDR_W-1:0] x, y;
  logic              pixelDataNext, startNext, clearErrorNext;
  logic              beat, addrClear, lastPixel;

  // pixReady is only ever high in ACCUM, so a beat implies ACCUM.
  assign beat = pixValid && pixReady;

  histogram_frame_controller_raster_addr_gen rasterAddrGen (
    .clk       (clk),
    .reset     (reset),
    .clear     (addrClear),
    .advance   (beat),
    .x         (x),
    .y         (y),
    .lastPixel (lastPixel)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      cycleCount     <= '0;
      pixReady       <= 1'b0;
      xAddress       <= '0;
      yAddress       <= '0;
      pixelData      <= 1'b0;
      startHistogram <= 1'b0;
      clearHistogram <= 1'b0;
      readHistogram  <= 1'b0;
      busy           <= 1'b0;
      frameDone      <= 1'b0;
      clearError     <= 1'b0;
    end else begin
      state          <= stateNext;
      cycleCount     <= cycleCountNext;
      xAddress       <= xAddressNext;
      yAddress       <= yAddressNext;
      pixelData      <= pixelDataNext;
      startHistogram <= startNext;
      clearError     <= clearErrorNext;
      pixReady       <= (stateNext == ACCUM);
      clearHistogram <= (stateNext == CLEAR);
      readHistogram  <= (stateNext == READ);
      busy           <= (stateNext != IDLE);
      frameDone      <= (stateNext == DONE);
    end
  end

  always_comb begin
    stateNext      = state;
    cycleCountNext = cycleCount;
    clearErrorNext = clearError;
    xAddressNext   = xAddress;
    yAddressNext   = yAddress;
    pixelDataNext  = pixelData;
    startNext      = 1'b0;
    addrClear      = 1'b0;
    case (state)
      IDLE: begin
        if (frameStart) begin
          stateNext      = CLEAR;
          clearErrorNext = 1'b0;
          cycleCountNext = '0;
        end
      end
      CLEAR: begin
        cycleCountNext = cycleCount + 10'd1;
        if (histogramCleared) begin
          stateNext = SETTLE;
        end else if (cycleCount == CLEAR_LAST) begin
          stateNext      = DONE;
          clearErrorNext = 1'b1;
        end
      end
      SETTLE: begin
        // All strobes low for one cycle; rewind the raster to the origin.
        addrClear = 1'b1;
        stateNext = ACCUM;
      end
      ACCUM: begin
        if (beat) begin
          startNext     = 1'b1;
          xAddressNext  = x;
          yAddressNext  = y;
          pixelDataNext = pixData;
          if (lastPixel) begin
            stateNext = FLUSH;
          end
        end
      end
      FLUSH: begin
        // The final accumulate strobe is on the bus during this cycle.
        stateNext      = READ;
        cycleCountNext = '0;
      end
      READ: begin
        cycleCountNext = cycleCount + 10'd1;
        if (cycleCount == READ_LAST) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_histogram_frame_controller.sv
// Self-checking bench for histogram_frame_controller. A behavioural
// histogram stands in for the real block; expected pixel beats and expected
// per-bin read-out values are queued when stimulus is driven and popped
// when the controller / histogram produce them.
module tb_histogram_frame_controller;
  import histogram_frame_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset, frameStart, pixValid, pixData, histogramCleared;
  logic       pixReady, pixelData, startHistogram, clearHistogram;
  logic       readHistogram, busy, frameDone, clearError;
  logic [7:0] xAddress, yAddress;

  always #5 clk = ~clk;

  histogram_frame_controller dut (
    .clk              (clk),
    .reset            (reset),
    .frameStart       (frameStart),
    .pixValid         (pixValid),
    .pixData          (pixData),
    .pixReady         (pixReady),
    .xAddress         (xAddress),
    .yAddress         (yAddress),
    .pixelData        (pixelData),
    .startHistogram   (startHistogram),
    .clearHistogram   (clearHistogram),
    .histogramCleared (histogramCleared),
    .readHistogram    (readHistogram),
    .busy             (busy),
    .frameDone        (frameDone),
    .clearError       (clearError)
  );

  // ---------------- behavioural histogram ----------------
  logic [7:0] xHist [IMWIDTH];
  logic [7:0] yHist [IMHEIGHT];
  int         clrCnt;
  bit         clearStuck;

  always @(posedge clk) begin
    if (!reset) begin
      clrCnt           <= 0;
      histogramCleared <= 1'b0;
    end else if (clearHistogram) begin
      clrCnt           <= clrCnt + 1;
      histogramCleared <= !clearStuck && (clrCnt == 3);
      if (clrCnt == 0) begin
        for (int i = 0; i < IMWIDTH; i++)  xHist[i] <= 8'd0;
        for (int i = 0; i < IMHEIGHT; i++) yHist[i] <= 8'd0;
      end
    end else begin
      clrCnt           <= 0;
      histogramCleared <= 1'b0;
    end
    if (startHistogram && pixelData &&
        int'(xAddress) < IMWIDTH && int'(yAddress) < IMHEIGHT) begin
      xHist[xAddress] <= xHist[xAddress] + 8'd1;
      yHist[yAddress] <= yHist[yAddress] + 8'd1;
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       d;
  } beat_t;

  beat_t      beatQ[$];
  int         expXq[$];
  int         expYq[$];
  int         checks = 0;
  int         errors = 0;
  int         startCount, clrCycles, readLen, readRuns, doneCount;
  bit         prevRead, holdChk, haveLast;
  logic [7:0] lastX, lastY;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; all DUT outputs are sampled 1 time unit after the edge.
  task automatic tick();
    beat_t e;
    int    k, v;
    @(posedge clk);
    #1;
    checks++;
    assert ((int'(startHistogram) + int'(clearHistogram) + int'(readHistogram)) <= 1) else begin
      errors++;
      $error("FAIL strobeExclusive observed start=%0b clear=%0b read=%0b expected at most one",
             startHistogram, clearHistogram, readHistogram);
    end
    if (startHistogram) begin
      startCount++;
      checks++;
      assert (beatQ.size() > 0) else begin
        errors++;
        $error("FAIL beatQueue observed startHistogram with no beat expected no strobe");
      end
      if (beatQ.size() > 0) begin
        e = beatQ.pop_front();
        checks++;
        assert ({xAddress, yAddress, pixelData} === {e.x, e.y, e.d}) else begin
          errors++;
          $error("FAIL beatAddr observed x=%0d y=%0d d=%0b expected x=%0d y=%0d d=%0b",
                 xAddress, yAddress, pixelData, e.x, e.y, e.d);
        end
        lastX    = e.x;
        lastY    = e.y;
        haveLast = 1'b1;
      end
    end else if (holdChk && haveLast) begin
      checks++;
      assert ({xAddress, yAddress} === {lastX, lastY}) else begin
        errors++;
        $error("FAIL addrHold observed x=%0d y=%0d expected x=%0d y=%0d",
               xAddress, yAddress, lastX, lastY);
      end
    end
    if (clearHistogram) clrCycles++;
    if (readHistogram) begin
      if (!prevRead) readRuns++;
      k = readLen;
      readLen++;
      if (k < IMWIDTH) begin
        checks++;
        assert (expXq.size() > 0) else begin
          errors++;
          $error("FAIL xBinQueue observed extra read cycle %0d expected none", k);
        end
        if (expXq.size() > 0) begin
          v = expXq.pop_front();
          checks++;
          assert (int'(xHist[k]) === v) else begin
            errors++;
            $error("FAIL xBin[%0d] observed=%0d expected=%0d", k, xHist[k], v);
          end
        end
      end
      if (k < IMHEIGHT && expYq.size() > 0) begin
        v = expYq.pop_front();
        checks++;
        assert (int'(yHist[k]) === v) else begin
          errors++;
          $error("FAIL yBin[%0d] observed=%0d expected=%0d", k, yHist[k], v);
        end
      end
    end
    prevRead = readHistogram;
    if (frameDone) doneCount++;
  endtask

  task automatic checkAllZero(input string tag);
    check(tag, {22'd0, pixReady, xAddress, yAddress, pixelData, startHistogram, clearHistogram,
                readHistogram, busy, frameDone, clearError} & 32'h3FFFFFF, 32'd0);
  endtask

  // One frame. abortAt>0: pull reset at that beat count and return.
  task automatic runFrame(input bit allOnes, input int bubbleBeats, input int abortAt,
                          input bit pokeStart);
    int    ex, ey, beats, cyc;
    beat_t e;
    ex = 0; ey = 0; beats = 0; cyc = 0;
    startCount = 0; clrCycles = 0; readLen = 0; readRuns = 0; doneCount = 0;
    beatQ.delete(); expXq.delete(); expYq.delete();
    haveLast = 1'b0;
    holdChk  = (bubbleBeats > 0);
    if (abortAt == 0) begin
      for (int i = 0; i < IMWIDTH; i++)
        expXq.push_back(allOnes ? IMHEIGHT : ((i < IMHEIGHT) ? 1 : 0));
      for (int i = 0; i < IMHEIGHT; i++)
        expYq.push_back(allOnes ? IMWIDTH : 1);
    end
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    while (beats < IMWIDTH * IMHEIGHT && cyc < 100000) begin
      pixValid = (beats < bubbleBeats) ? (cyc % 2 == 0) : 1'b1;
      pixData  = allOnes ? 1'b1 : (ex == ey);
      if (abortAt > 0 && beats == abortAt) begin
        reset    = 1'b0;
        pixValid = 1'b0;
        tick();
        checkAllZero("midFrameResetOutputs");
        reset = 1'b1;
        beatQ.delete();
        tick();
        check("busyAfterAbort", busy, 0);
        return;
      end
      frameStart = pokeStart && (beats == 5000);
      if (pixValid && pixReady) begin
        e.x = 8'(ex);
        e.y = 8'(ey);
        e.d = pixData;
        beatQ.push_back(e);
        beats++;
        if (ex == IMWIDTH - 1) begin
          ex = 0;
          ey++;
        end else begin
          ex++;
        end
      end
      tick();
      cyc++;
    end
    pixValid   = 1'b0;
    frameStart = 1'b0;
    check("beatsAccepted", beats, IMWIDTH * IMHEIGHT);
    check("pixReadyDropAfterLast", pixReady, 0);
    cyc = 0;
    while (doneCount == 0 && cyc < 2000) begin
      frameStart = pokeStart && (readLen == 100);
      tick();
      cyc++;
    end
    frameStart = 1'b0;
    check("frameDoneSeen", doneCount, 1);
    repeat (5) tick();
    check("frameDoneOnce", doneCount, 1);
    check("idleAfterFrame", busy, 0);
    check("startPulses", startCount, IMWIDTH * IMHEIGHT);
    // model raises histogramCleared on the 4th clear cycle; the controller
    // drops the request one cycle after seeing it
    check("clearCycles", clrCycles, 5);
    check("readLength", readLen, READ_LEN);
    check("readContiguous", readRuns, 1);
    check("xBinsDrained", expXq.size(), 0);
    check("yBinsDrained", expYq.size(), 0);
    check("noClearError", clearError, 0);
  endtask

  initial begin
    int cyc;
    reset      = 1'b0;
    frameStart = 1'b1;
    pixValid   = 1'b0;
    pixData    = 1'b0;
    clearStuck = 1'b0;
    holdChk    = 1'b0;
    haveLast   = 1'b0;
    prevRead   = 1'b0;
    startCount = 0; clrCycles = 0; readLen = 0; readRuns = 0; doneCount = 0;

    // reset held with frameStart high
    repeat (3) tick();
    checkAllZero("resetOutputs");
    reset      = 1'b1;
    frameStart = 1'b0;
    repeat (5) tick();
    check("idleAfterReset", busy, 0);

    // abort at beat 1000, then full frames
    runFrame(1'b1, 0, 1000, 1'b0);
    runFrame(1'b1, 0, 0, 1'b1);
    runFrame(1'b0, 200, 0, 1'b0);

    // clear sweep never completes
    holdChk    = 1'b0;
    clearStuck = 1'b1;
    startCount = 0; clrCycles = 0; readLen = 0; doneCount = 0;
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    cyc = 0;
    while (doneCount == 0 && cyc < 1000) begin
      tick();
      cyc++;
    end
    check("timeoutDone", doneCount, 1);
    check("timeoutClearError", clearError, 1);
    check("timeoutClearCycles", clrCycles, CLEAR_TIMEOUT);
    check("timeoutNoStart", startCount, 0);
    check("timeoutNoRead", readLen, 0);
    repeat (3) tick();
    check("clearErrorSticky", clearError, 1);
    check("timeoutIdle", busy, 0);
    clearStuck = 1'b0;
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    check("clearErrorClearedOnStart", clearError, 0);
    check("busyOnRestart", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkAllZero("finalResetOutputs");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
